// File: rtl/ifetch_queue_if.sv
// Fetch-stage bundle: PC handshake, instruction-memory bus and decode-side queue head.
interface ifetch_queue_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] pcf;
    logic             pc_advance;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;
    logic [WIDTH-1:0] instrd;
    logic [WIDTH-1:0] pcplus4d;
    logic             validd;
    logic             stalld;
    logic             flush;

    modport master (
        input  pcf, imem_gnt, imem_rvalid, imem_rdata, stalld, flush,
        output pc_advance, imem_req, imem_addr, instrd, pcplus4d, validd
    );

    modport slave (
        output pcf, imem_gnt, imem_rvalid, imem_rdata, stalld, flush,
        input  pc_advance, imem_req, imem_addr, instrd, pcplus4d, validd
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch: one outstanding imem read per PC, results held in an in-order
// first-word-fall-through queue drained by decode; flush drops queued and in-flight words.
module ifetch_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_queue_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t           state;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW:0]      count;
    logic [WIDTH-1:0] pend_pc4;
    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [WIDTH-1:0] pc4_mem   [DEPTH];

    logic grant;
    logic push;
    logic pop;

    always_comb begin
        bus.imem_req   = !reset && (state == IDLE) && (count < DEPTH_C) && !bus.flush;
        bus.imem_addr  = bus.pcf & ~WIDTH'(3);
        grant          = bus.imem_req && bus.imem_gnt;
        bus.pc_advance = grant;
        bus.validd     = (count != '0);
        bus.instrd     = bus.validd ? instr_mem[head] : '0;
        bus.pcplus4d   = bus.validd ? pc4_mem[head]   : '0;
        push           = (state == WAIT) && bus.imem_rvalid && !bus.flush;
        pop            = bus.validd && !bus.stalld && !bus.flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pend_pc4 <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc4_mem[i]   <= '0;
            end
        end else if (bus.flush) begin
            // A read still in flight must be absorbed in DROP so its late data never lands.
            head  <= '0;
            tail  <= '0;
            count <= '0;
            case (state)
                WAIT:    state <= bus.imem_rvalid ? IDLE : DROP;
                DROP:    state <= bus.imem_rvalid ? IDLE : DROP;
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: if (grant) state <= WAIT;
                WAIT: if (bus.imem_rvalid) state <= IDLE;
                DROP: if (bus.imem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (grant) pend_pc4 <= bus.pcf + WIDTH'(4);
            if (push) begin
                instr_mem[tail] <= bus.imem_rdata;
                pc4_mem[tail]   <= pend_pc4;
                tail            <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: issue/latency, full-queue backpressure, flush cases, async reset.
module tb_ifetch_queue;
    logic clk;
    logic reset;
    int unsigned tests;
    int unsigned fails;

    ifetch_queue_if #(.WIDTH(32)) bus ();

    ifetch_queue #(.WIDTH(32), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant in this cycle, response in the next; returns one cycle after the push.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
        bus.pcf      = pc;
        bus.imem_gnt = 1'b1;
        #1;
        check("fetch_adv", {31'd0, bus.pc_advance}, 32'd1);
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        tick();
        bus.imem_rvalid = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        bus.pcf = '0;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        bus.stalld = 1'b0;
        bus.flush = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_validd", {31'd0, bus.validd}, 32'd0);
        check("rst_instrd", bus.instrd, 32'd0);
        check("rst_pcplus4d", bus.pcplus4d, 32'd0);
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_adv", {31'd0, bus.pc_advance}, 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Basic fetch: grant N, rvalid N+1, visible N+2
        bus.pcf = 32'h0040_0000;
        bus.imem_gnt = 1'b1;
        #1;
        check("t1_req", {31'd0, bus.imem_req}, 32'd1);
        check("t1_addr", bus.imem_addr, 32'h0040_0000);
        check("t1_adv", {31'd0, bus.pc_advance}, 32'd1);
        tick();
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h8FA8_0004;
        #1;
        check("t1_wait_req", {31'd0, bus.imem_req}, 32'd0);
        check("t1_wait_validd", {31'd0, bus.validd}, 32'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        #1;
        check("t1_validd", {31'd0, bus.validd}, 32'd1);
        check("t1_instrd", bus.instrd, 32'h8FA8_0004);
        check("t1_pcplus4d", bus.pcplus4d, 32'h0040_0004);
        check("t1_reissue", {31'd0, bus.imem_req}, 32'd1);
        tick();
        #1;
        check("t1_popped", {31'd0, bus.validd}, 32'd0);

        // Fill the queue under stall, then drain in order
        bus.stalld = 1'b1;
        for (int i = 0; i < 4; i++)
            fetch(32'(i * 4), 32'h1111_0000 + 32'(i));
        bus.pcf = 32'h10;
        bus.imem_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t2_full_req", {31'd0, bus.imem_req}, 32'd0);
            check("t2_full_adv", {31'd0, bus.pc_advance}, 32'd0);
            tick();
        end
        bus.imem_gnt = 1'b0;
        bus.stalld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_validd", {31'd0, bus.validd}, 32'd1);
            check("t2_instrd", bus.instrd, 32'h1111_0000 + 32'(i));
            check("t2_pcplus4d", bus.pcplus4d, 32'(i * 4 + 4));
            check("t2_req", {31'd0, bus.imem_req}, (i == 0) ? 32'd0 : 32'd1);
            tick();
        end
        #1;
        check("t2_empty", {31'd0, bus.validd}, 32'd0);
        check("t2_empty_instrd", bus.instrd, 32'd0);
        check("t2_empty_pcplus4d", bus.pcplus4d, 32'd0);
        tick();

        // Flush in IDLE suppresses the request; flush after grant drops the late data
        bus.pcf = 32'h0040_0000;
        bus.flush = 1'b1;
        #1;
        check("t3_idle_flush_req", {31'd0, bus.imem_req}, 32'd0);
        bus.flush = 1'b0;
        #1;
        check("t3_idle_req", {31'd0, bus.imem_req}, 32'd1);
        bus.imem_gnt = 1'b1;
        #1;
        check("t3_adv", {31'd0, bus.pc_advance}, 32'd1);
        tick();
        bus.imem_gnt = 1'b0;
        bus.flush = 1'b1;
        bus.pcf = 32'h0040_0100;
        #1;
        check("t3_flush_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        check("t3_drop_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("t3_drop_rv_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        #1;
        check("t3_validd", {31'd0, bus.validd}, 32'd0);
        check("t3_instrd", bus.instrd, 32'd0);
        check("t3_req", {31'd0, bus.imem_req}, 32'd1);
        check("t3_addr", bus.imem_addr, 32'h0040_0100);
        tick();

        // Flush coinciding with rvalid while two entries are queued
        bus.stalld = 1'b1;
        fetch(32'h0, 32'hAAAA_0000);
        fetch(32'h4, 32'hAAAA_0004);
        bus.pcf = 32'h8;
        bus.imem_gnt = 1'b1;
        #1;
        check("t4_adv", {31'd0, bus.pc_advance}, 32'd1);
        tick();
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h0000_0BAD;
        bus.flush = 1'b1;
        #1;
        check("t4_pre_validd", {31'd0, bus.validd}, 32'd1);
        check("t4_pre_instrd", bus.instrd, 32'hAAAA_0000);
        tick();
        bus.imem_rvalid = 1'b0;
        bus.flush = 1'b0;
        #1;
        check("t4_validd", {31'd0, bus.validd}, 32'd0);
        check("t4_instrd", bus.instrd, 32'd0);
        check("t4_req", {31'd0, bus.imem_req}, 32'd1);
        fetch(32'h40, 32'h1234_5678);
        #1;
        check("t4_new_validd", {31'd0, bus.validd}, 32'd1);
        check("t4_new_instrd", bus.instrd, 32'h1234_5678);
        check("t4_new_pcplus4d", bus.pcplus4d, 32'h44);
        bus.stalld = 1'b0;
        tick();
        #1;
        check("t4_drained", {31'd0, bus.validd}, 32'd0);

        // Request held without grant: address stable and word aligned
        bus.pcf = 32'h0040_0003;
        bus.imem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t5_req", {31'd0, bus.imem_req}, 32'd1);
            check("t5_addr", bus.imem_addr, 32'h0040_0000);
            check("t5_adv", {31'd0, bus.pc_advance}, 32'd0);
            tick();
        end

        // PC+4 wraps, then async reset in WAIT with three entries queued
        bus.stalld = 1'b1;
        fetch(32'hFFFF_FFFC, 32'h0000_00A0);
        #1;
        check("t6_wrap_validd", {31'd0, bus.validd}, 32'd1);
        check("t6_wrap_pcplus4d", bus.pcplus4d, 32'd0);
        check("t6_wrap_instrd", bus.instrd, 32'h0000_00A0);
        fetch(32'h100, 32'h0000_00A1);
        fetch(32'h104, 32'h0000_00A2);
        bus.pcf = 32'h108;
        bus.imem_gnt = 1'b1;
        #1;
        check("t6_adv", {31'd0, bus.pc_advance}, 32'd1);
        tick();
        #1;
        check("t6_pre_validd", {31'd0, bus.validd}, 32'd1);
        check("t6_pre_req", {31'd0, bus.imem_req}, 32'd0);
        reset = 1'b1;
        #1;
        check("t6_validd", {31'd0, bus.validd}, 32'd0);
        check("t6_instrd", bus.instrd, 32'd0);
        check("t6_pcplus4d", bus.pcplus4d, 32'd0);
        check("t6_req", {31'd0, bus.imem_req}, 32'd0);
        check("t6_adv", {31'd0, bus.pc_advance}, 32'd0);
        tick();
        #1;
        check("t6_held_req", {31'd0, bus.imem_req}, 32'd0);
        reset = 1'b0;
        bus.imem_gnt = 1'b0;
        #1;
        check("t6_post_req", {31'd0, bus.imem_req}, 32'd1);
        check("t6_post_addr", bus.imem_addr, 32'h108);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
